dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Round-robin arbiter sharing the single DRAM controller user port (one-word read/write, one transaction in flight) among NUM_REQ requesters (CPU, DMA/disk, framebuffer). Sits between the requesters and the AXI DRAM controller: latches the winning request, issues a one-cycle rd/wr enable when the controller is ready, tracks completion, and returns read data and a per-requester completion pulse.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 28, word address width
- DATA_WIDTH, 128, data word width
- MASK_WIDTH, 16, byte mask width (1 = byte masked off)

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  synchronous, active-high reset
- i_req_rd  in  NUM_REQ  per-requester read request, held until ack
- i_req_wr  in  NUM_REQ  per-requester write request, held until ack
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_data  in  NUM_REQ*DATA_WIDTH  flattened write data
- i_req_mask  in  NUM_REQ*MASK_WIDTH  flattened write masks
- o_req_ack  out  NUM_REQ  one-cycle completion pulse to granted requester
- o_req_rdata  out  DATA_WIDTH  read data, valid with o_req_ack on reads
- o_busy  out  1  transaction in flight
- o_dram_rd_en  out  1  controller read enable
- o_dram_wr_en  out  1  controller write enable
- o_dram_addr  out  ADDR_WIDTH  controller address
- o_dram_data  out  DATA_WIDTH  controller write data
- o_dram_mask  out  MASK_WIDTH  controller write mask
- i_dram_ready  in  1  controller idle/ready
- i_dram_data  in  DATA_WIDTH  controller read data
- i_dram_data_valid  in  1  controller read data valid

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT.
- IDLE: if i_dram_ready and any request, select winner by round-robin starting at ptr; register grant index g, op (write if i_req_wr[g], else read; write wins if both), addr/data/mask; assert matching enable; -> ISSUE. Otherwise hold.
- ISSUE: enables high exactly this cycle; deassert; -> SETTLE.
- SETTLE: one dead cycle (controller's registered ready is still stale); -> WAIT.
- WAIT, read: on i_dram_data_valid capture i_dram_data into o_req_rdata, pulse o_req_ack[g] next cycle, ptr <= g+1 mod NUM_REQ, -> IDLE.
- WAIT, write: on i_dram_ready high, pulse o_req_ack[g] next cycle, ptr update, -> IDLE.
- Round-robin: priority order ptr, ptr+1, ..., wrap; granted requester is lowest priority next round. No starvation: any held request served within NUM_REQ transactions.
- o_dram_addr/data/mask hold latched values from IDLE grant until next grant.
- Requester must hold req and payload until ack; payload changes after grant are ignored. Request dropped before ack: transaction still completes, ack still pulsed.
- o_busy = state != IDLE.

## Timing
- Reset: state IDLE, ptr 0, o_dram_rd_en/wr_en 0, o_req_ack 0, o_busy 0, o_dram_addr/data/mask 0, o_req_rdata 0.
- Grant at cycle T (IDLE, ready, request) -> enable high T+1 -> WAIT from T+3.
- Read ack: one cycle after i_dram_data_valid; o_req_rdata stable until next read capture.
- Write ack: one cycle after first i_dram_ready seen in WAIT.
- Ack pulse and return to IDLE on same edge; a new grant possible the following cycle if i_dram_ready high (requester whose ack is pulsing must have dropped req that cycle, else it is re-granted at lowest priority).
- i_dram_data_valid outside WAIT-read ignored. i_dram_ready low in IDLE: no grant.
- Reset mid-transaction: all state cleared, no ack issued; in-flight controller op abandoned.

## Structure
- Package dram_arb_pkg: state encoding localparams (IDLE/ISSUE/SETTLE/WAIT), op encoding (OP_RD, OP_WR).
- Sub-module rr_arbiter: combinational rotate-priority pick (inputs req vector, ptr; outputs one-hot grant, index, any), parameterised by NUM_REQ.

## Test plan
- Single read, req 1 addr 0x0000100, model returns 0x...DEAD valid 5 cycles after enable -> o_dram_rd_en one pulse addr 0x0000100; o_req_ack[1] and o_req_rdata=0x...DEAD one cycle after valid.
- Single write, req 0 data 0xA5..A5 mask 0x00F0 -> o_dram_wr_en one pulse, data/mask match, ack[0] one cycle after ready returns.
- All three requesters read continuously, ptr 0 -> grant order 0,1,2,0,1,2; exactly one enable per ack.
- Requester 2 asserts rd and wr together -> write issued, one ack.
- i_dram_ready low for 20 cycles with pending requests -> no enables; grant within one cycle of ready rising.
- i_rst asserted during WAIT -> next cycle all outputs 0, no ack; fresh request after reset served from requester 0 priority.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM user-port arbiter: FSM state encoding and operation codes.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StSettle = 2'd2,
    StWait   = 2'd3
  } arb_state_e;

  localparam logic OpRd = 1'b0;
  localparam logic OpWr = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: requester i_ptr has top priority, then i_ptr+1, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned k;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(i_ptr) + i) % NUM_REQ;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_idx    = IdxW'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter multiplexing several one-word requesters onto the single DRAM controller
// user port, one transaction in flight at a time.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_rd,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] i_req_mask,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic [DATA_WIDTH-1:0]         o_req_rdata,
  output logic                          o_busy,
  output logic                          o_dram_rd_en,
  output logic                          o_dram_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_dram_addr,
  output logic [DATA_WIDTH-1:0]         o_dram_data,
  output logic [MASK_WIDTH-1:0]         o_dram_mask,
  input  logic                          i_dram_ready,
  input  logic [DATA_WIDTH-1:0]         i_dram_data,
  input  logic                          i_dram_data_valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]    arb_gnt, gnt_q, ack_q;
  logic [IdxW-1:0]       arb_idx, idx_q, ptr_q;
  logic                  arb_any, op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic                  grant, done;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .i_req(i_req_rd | i_req_wr),
    .i_ptr(ptr_q),
    .o_gnt(arb_gnt),
    .o_idx(arb_idx),
    .o_any(arb_any)
  );

  assign grant = (state_q == StIdle) && i_dram_ready && arb_any;
  // Writes complete when the controller goes ready again; reads on returned data.
  assign done  = (state_q == StWait) &&
                 ((op_q == OpWr) ? i_dram_ready : i_dram_data_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant) state_d = StIssue;
      StIssue:  state_d = StSettle;
      // Controller's ready is registered, so it still looks idle for one cycle after the enable.
      StSettle: state_d = StWait;
      StWait:   if (done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    o_dram_rd_en = (state_q == StIssue) && (op_q == OpRd);
    o_dram_wr_en = (state_q == StIssue) && (op_q == OpWr);
    o_busy       = (state_q != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      op_q    <= OpRd;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      if (grant) begin
        gnt_q  <= arb_gnt;
        idx_q  <= arb_idx;
        op_q   <= i_req_wr[arb_idx] ? OpWr : OpRd;
        addr_q <= i_req_addr[32'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        data_q <= i_req_data[32'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        mask_q <= i_req_mask[32'(arb_idx)*MASK_WIDTH +: MASK_WIDTH];
      end
      if (done) begin
        ack_q <= gnt_q;
        // The requester just served drops to lowest priority.
        ptr_q <= (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
        if (op_q == OpRd) rdata_q <= i_dram_data;
      end
    end
  end

  assign o_req_ack   = ack_q;
  assign o_req_rdata = rdata_q;
  assign o_dram_addr = addr_q;
  assign o_dram_data = data_q;
  assign o_dram_mask = mask_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: requester drivers, a DRAM controller model, and a
// cycle monitor checking grants, enables and acks against a round-robin reference model.
module tb_dram_arbiter;

  localparam int NR = 3;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_rd = '0, req_wr = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR*MW-1:0]  req_mask = '0;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              busy, rd_en, wr_en;
  logic [AW-1:0]     dram_addr;
  logic [DW-1:0]     dram_data;
  logic [MW-1:0]     dram_mask;
  logic              dram_ready, dram_valid;
  logic [DW-1:0]     dram_dout;

  dram_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_mask(req_mask),
    .o_req_ack(ack), .o_req_rdata(rdata), .o_busy(busy),
    .o_dram_rd_en(rd_en), .o_dram_wr_en(wr_en),
    .o_dram_addr(dram_addr), .o_dram_data(dram_data), .o_dram_mask(dram_mask),
    .i_dram_ready(dram_ready), .i_dram_data(dram_dout), .i_dram_data_valid(dram_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[NR][$];
  int   grant_q[$];
  int   grant_log[$];
  int   checks = 0, passes = 0;

  logic [DW-1:0] dram_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];

  int   cyc = 0;
  logic rst_e = 1'b1;
  bit   hold_off = 1'b0;
  int   fixed_lat = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return (a == 28'h100) ? 128'hdead : {4{4'hA, a}};
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                          logic [MW-1:0] m);
    logic [DW-1:0] r = old;
    for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] dram_get(logic [AW-1:0] a);
    return dram_mem.exists(a) ? dram_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_get(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic int rr_pick(logic [NR-1:0] r, int p);
    for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
    return 0;
  endfunction

  // DRAM controller model: ready drops after an enable, returns after lat cycles.
  initial begin : dram_model
    logic [AW-1:0] a;
    logic          w;
    int            lat;
    dram_ready = 1'b1;
    dram_valid = 1'b0;
    dram_dout  = '0;
    forever begin
      @(posedge clk); #1;
      dram_valid = 1'b0;
      if (rd_en || wr_en) begin
        a = dram_addr;
        w = wr_en;
        if (w) dram_mem[a] = merge(dram_get(a), dram_data, dram_mask);
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 7));
        for (int i = 1; i <= lat; i++) begin
          @(posedge clk); #1;
          if (i == 1) dram_ready = 1'b0;
          if (i == lat) begin
            dram_ready = 1'b1;
            if (!w) begin
              dram_valid = 1'b1;
              dram_dout  = dram_get(a);
            end
          end
        end
      end else begin
        dram_ready = !hold_off;
      end
    end
  end

  // Reference model state, carried from one cycle to the next.
  logic [NR-1:0] p_req = '0, p_wr = '0;
  logic          p_ready = 1'b0, p_done = 1'b0, p_infl = 1'b0;
  logic          infl = 1'b0, inf_rd = 1'b0;
  int            en_cyc = 0, mptr = 0, n_en = 0, n_ack = 0, n_abandon = 0;

  always @(negedge clk) begin : monitor
    logic [NR-1:0] exp_ack;
    int            win;
    rsp_t          r;
    if (rst_e) begin
      if (infl) n_abandon++;
      infl = 1'b0;
      mptr = 0;
      grant_q.delete();
      chk("rst_ack", DW'(ack), '0);
      chk("rst_en", DW'({rd_en, wr_en}), '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_addr", DW'(dram_addr), '0);
      chk("rst_wdata", dram_data, '0);
      chk("rst_mask", DW'(dram_mask), '0);
      chk("rst_rdata", rdata, '0);
    end else begin
      exp_ack = '0;
      if (p_done) exp_ack[grant_q[0]] = 1'b1;
      if (exp_ack != '0 || ack != '0) chk("ack_vec", DW'(ack), DW'(exp_ack));
      if (p_done) begin
        win  = grant_q.pop_front();
        infl = 1'b0;
        n_ack++;
        if (exp_q[win].size() == 0) begin
          checks++;
          $display("FAIL scoreboard: ack for req%0d with nothing expected", win);
        end else begin
          r = exp_q[win].pop_front();
          if (r.rd) chk("rdata", rdata, r.data);
        end
      end
      chk("enable", DW'(rd_en | wr_en), DW'(!p_infl && p_ready && (p_req != '0)));
      if (!p_infl && p_ready && (p_req != '0)) begin
        win = rr_pick(p_req, mptr);
        chk("rd_en", DW'(rd_en), DW'(!p_wr[win]));
        chk("wr_en", DW'(wr_en), DW'(p_wr[win]));
        chk("dram_addr", DW'(dram_addr), DW'(req_addr[win*AW +: AW]));
        if (p_wr[win]) begin
          chk("dram_data", dram_data, req_data[win*DW +: DW]);
          chk("dram_mask", DW'(dram_mask), DW'(req_mask[win*MW +: MW]));
        end
        grant_q.push_back(win);
        grant_log.push_back(win);
        mptr   = (win + 1) % NR;
        infl   = 1'b1;
        inf_rd = !p_wr[win];
        en_cyc = cyc;
        n_en++;
      end
      chk("busy", DW'(busy), DW'(infl));
    end
    p_infl  = infl;
    p_req   = req_rd | req_wr;
    p_wr    = req_wr;
    p_ready = dram_ready;
    p_done  = infl && (cyc >= en_cyc + 2) && (inf_rd ? dram_valid : dram_ready);
  end

  // Issue one request, queue its expected response, hold until ack.
  task automatic do_req(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    rsp_t r;
    int   n;
    r.rd = !wr;
    if (wr) begin
      ref_mem[a] = merge(ref_get(a), d, m);
      r.data = '0;
    end else begin
      r.data = ref_get(a);
    end
    exp_q[k].push_back(r);
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
    req_mask[k*MW +: MW] = m;
    req_rd[k] = rd;
    req_wr[k] = wr;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack[k] && n < 1000);
    if (!ack[k]) begin
      checks++;
      $display("FAIL ack_timeout: req%0d got no ack within %0d cycles", k, n);
    end
    req_rd[k] = 1'b0;
    req_wr[k] = 1'b0;
  endtask

  task automatic cont_reads(input int k);
    for (int i = 0; i < 2; i++) begin
      do_req(k, 1'b1, 1'b0, AW'((k << 8) | i), '0, '0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_driver(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int op;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      op = int'($urandom_range(0, 2));
      do_req(k, op != 1, op != 0, AW'((k << 8) | int'($urandom_range(0, 7))),
             {$urandom(), $urandom(), $urandom(), $urandom()}, MW'($urandom()));
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back reads from all three, starting from pointer 0.
    grant_log.delete();
    fork
      cont_reads(0);
      cont_reads(1);
      cont_reads(2);
    join
    chk("order_len", DW'(grant_log.size()), DW'(6));
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("order", DW'(grant_log[i]), DW'(exp_order[i]));

    // Single read with fixed 5-cycle latency.
    fixed_lat = 5;
    do_req(1, 1'b1, 1'b0, 28'h100, '0, '0);
    chk("single_rd_rdata", rdata, 128'hdead);
    fixed_lat = 0;

    // Single masked write, then read back.
    do_req(0, 1'b0, 1'b1, 28'h005, {16{8'hA5}}, 16'h00F0);
    @(posedge clk); #1;
    do_req(0, 1'b1, 1'b0, 28'h005, '0, '0);
    chk("wr_readback", rdata, merge(init_word(28'h005), {16{8'hA5}}, 16'h00F0));

    // Read and write asserted together: write wins.
    grant_log.delete();
    do_req(2, 1'b1, 1'b1, 28'h205, {4{32'h1234_5678}}, 16'h0000);
    chk("rdwr_grants", DW'(grant_log.size()), DW'(1));

    // Controller not ready for 20 cycles with requests pending.
    hold_off = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fork
      do_req(0, 1'b1, 1'b0, 28'h003, '0, '0);
      do_req(2, 1'b0, 1'b1, 28'h203, {4{32'hCAFE_F00D}}, 16'hFF00);
      begin
        repeat (20) @(posedge clk);
        #1 hold_off = 1'b0;
      end
    join

    // Random traffic from all requesters.
    fork
      rand_driver(0, 25);
      rand_driver(1, 25);
      rand_driver(2, 25);
    join

    // Reset while a read is in WAIT; the op is abandoned without ack.
    repeat (2) @(posedge clk);
    #1;
    fixed_lat = 10;
    req_addr[1*AW +: AW] = 28'h101;
    req_rd[1] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_en && n < 50);
    chk("mid_rst_enable_seen", DW'(rd_en), DW'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_rd[1] = 1'b0;
    fixed_lat = 0;
    repeat (15) @(posedge clk);
    #1;
    grant_log.delete();
    fork
      do_req(0, 1'b1, 1'b0, 28'h006, '0, '0);
      do_req(1, 1'b1, 1'b0, 28'h106, '0, '0);
      do_req(2, 1'b1, 1'b0, 28'h206, '0, '0);
    join
    chk("post_rst_first", DW'(grant_log.size() > 0 ? grant_log[0] : -1), DW'(0));

    repeat (5) @(posedge clk);
    #1;
    chk("enables_vs_acks", DW'(n_en), DW'(n_ack + n_abandon));
    chk("sb_empty", DW'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), DW'(0));
    chk("grants_drained", DW'(grant_q.size()), DW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
